decoder_scan_n: RTL and testbench

- Parametrised, registered IN_W-to-2^IN_W one-hot decoder; successor to the fixed 3-to-8 enable decoder.
- Adds a one-hot scan sequencer (up/down) with a programmable step divider, index load, hold mode, step/wrap strobes and selectable output polarity.
- Used for row/digit select and channel strobing where either the decode index is driven externally or the block walks through all outputs autonomously.

---
 rtl/decoder_scan_n.sv | 146 ++++++++++++++
 tb/tb_decoder_scan_n.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_n.sv
// -----------------------------------------------------------------------------
// decoder_scan_n
//   Registered IN_W-to-2^IN_W one-hot decoder with a built-in scan sequencer.
//   The decode index is either driven directly or walked up/down by a scanner
//   that advances once every SCAN_DIV clocks. Output polarity is selectable.
//
// Parameters
//   IN_W       index width; OUT_W = 2**IN_W output lines
//   SCAN_DIV   clocks per scan step (1..65535)
//   ACTIVE_LOW 1 = selected line driven 0, inactive lines driven 1
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   enable  1 = drive decoded output, 0 = outputs inactive and state frozen
//   mode    00 direct, 01 scan up, 10 scan down, 11 hold
//   in      decode index (direct) / load value (scan, hold)
//   load    scan/hold: load idx from in
//   out     registered one-hot select
//   idx     registered current index
//   step    one-cycle pulse when the scanner advanced idx
//   wrap    one-cycle pulse when a scan step wrapped around
// -----------------------------------------------------------------------------
module decoder_scan_n #(
    parameter int IN_W       = 3,
    parameter int SCAN_DIV   = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [IN_W-1:0]      in,
    input  logic                 load,
    output logic [(2**IN_W)-1:0] out,
    output logic [IN_W-1:0]      idx,
    output logic                 step,
    output logic                 wrap
);

    localparam int OUT_W = 2**IN_W;
    localparam int DIV_W = $clog2(SCAN_DIV) + 1;

    localparam logic [IN_W-1:0]  IDX_MAX  = {IN_W{1'b1}};
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [OUT_W-1:0] INACTIVE = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    logic [IN_W-1:0]  idx_reg, idx_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic [OUT_W-1:0] out_reg, out_next;
    logic [OUT_W-1:0] onehot_next;
    logic             step_reg, step_next;
    logic             wrap_reg, wrap_next;
    logic [1:0]       mode_prev_reg;

    // Next-state for the index, divider and strobes.
    always_comb begin
        idx_next  = idx_reg;
        div_next  = div_reg;
        step_next = 1'b0;
        wrap_next = 1'b0;
        if (enable) begin
            case (mode)
                MODE_DIRECT: begin
                    idx_next = in;
                    div_next = '0;
                end
                MODE_HOLD: begin
                    if (load) begin
                        idx_next = in;
                    end
                    div_next = '0;
                end
                default: begin
                    if (load) begin
                        // Load wins over a step falling due on the same edge.
                        idx_next = in;
                        div_next = '0;
                    end else if (mode != mode_prev_reg) begin
                        // Fresh scan direction: restart the full step interval.
                        div_next = '0;
                    end else if (div_reg == DIV_LAST) begin
                        div_next  = '0;
                        step_next = 1'b1;
                        if (mode == MODE_UP) begin
                            idx_next  = idx_reg + IN_W'(1);
                            wrap_next = (idx_reg == IDX_MAX);
                        end else begin
                            idx_next  = idx_reg - IN_W'(1);
                            wrap_next = (idx_reg == '0);
                        end
                    end else begin
                        div_next = div_reg + DIV_W'(1);
                    end
                end
            endcase
        end
    end

    // Decode the index being registered this edge so out never lags idx.
    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_decode
            assign onehot_next[gi] = (idx_next == IN_W'(gi));
        end
    endgenerate

    always_comb begin
        out_next = INACTIVE;
        if (enable) begin
            out_next = ACTIVE_LOW ? ~onehot_next : onehot_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg       <= '0;
            div_reg       <= '0;
            out_reg       <= INACTIVE;
            step_reg      <= 1'b0;
            wrap_reg      <= 1'b0;
            // Track the mode present during reset so a scan that is already
            // selected steps exactly SCAN_DIV cycles after release.
            mode_prev_reg <= mode;
        end else begin
            idx_reg       <= idx_next;
            div_reg       <= div_next;
            out_reg       <= out_next;
            step_reg      <= step_next;
            wrap_reg      <= wrap_next;
            mode_prev_reg <= mode;
        end
    end

    assign out  = out_reg;
    assign idx  = idx_reg;
    assign step = step_reg;
    assign wrap = wrap_reg;

endmodule

// File: tb/tb_decoder_scan_n.sv
// -----------------------------------------------------------------------------
// tb_decoder_scan_n
//   Three decoder instances (3-bit/div 4, 3-bit/div 1, 4-bit active-low/div 3)
//   share clock and reset. Every clock each instance is compared with a
//   behavioural reference model; directed sequences add fixed expectations.
// -----------------------------------------------------------------------------
module tb_decoder_scan_n;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       en_a [3];
    logic [1:0] md_a [3];
    logic [3:0] in_a [3];
    logic       ld_a [3];

    logic [7:0]  out0, out1;
    logic [15:0] out2;
    logic [2:0]  idx0, idx1;
    logic [3:0]  idx2;
    logic        step0, step1, step2, wrap0, wrap1, wrap2;

    decoder_scan_n #(.IN_W(3), .SCAN_DIV(4), .ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .rst(rst), .enable(en_a[0]), .mode(md_a[0]), .in(in_a[0][2:0]),
        .load(ld_a[0]), .out(out0), .idx(idx0), .step(step0), .wrap(wrap0));

    decoder_scan_n #(.IN_W(3), .SCAN_DIV(1), .ACTIVE_LOW(1'b0)) dut1 (
        .clk(clk), .rst(rst), .enable(en_a[1]), .mode(md_a[1]), .in(in_a[1][2:0]),
        .load(ld_a[1]), .out(out1), .idx(idx1), .step(step1), .wrap(wrap1));

    decoder_scan_n #(.IN_W(4), .SCAN_DIV(3), .ACTIVE_LOW(1'b1)) dut2 (
        .clk(clk), .rst(rst), .enable(en_a[2]), .mode(md_a[2]), .in(in_a[2]),
        .load(ld_a[2]), .out(out2), .idx(idx2), .step(step2), .wrap(wrap2));

    // Reference model configuration and state.
    int p_inw [3] = '{3, 3, 4};
    int p_div [3] = '{4, 1, 3};
    int p_al  [3] = '{0, 0, 1};

    int          m_idx  [3];
    int          m_div  [3];
    int          m_prev [3];
    int          m_step [3];
    int          m_wrap [3];
    logic [31:0] m_out  [3];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_sel(input int k, input int i, input bit on);
        int n;
        logic [31:0] mask, oh;
        n    = 1 << p_inw[k];
        mask = 32'((64'd1 << n) - 64'd1);
        oh   = on ? (32'd1 << i) : 32'd0;
        return (p_al[k] != 0) ? (~oh & mask) : oh;
    endfunction

    // One clock edge of the specified behaviour, written with plain arithmetic.
    task automatic model_edge(input int k);
        int n;
        int md;
        n  = 1 << p_inw[k];
        md = int'(md_a[k]);
        m_step[k] = 0;
        m_wrap[k] = 0;
        if (rst) begin
            m_idx[k] = 0;
            m_div[k] = 0;
            m_out[k] = model_sel(k, 0, 1'b0);
        end else if (!en_a[k]) begin
            m_out[k] = model_sel(k, 0, 1'b0);
        end else begin
            if (md == 0) begin
                m_idx[k] = int'(in_a[k]) % n;
                m_div[k] = 0;
            end else if (md == 3) begin
                if (ld_a[k]) m_idx[k] = int'(in_a[k]) % n;
                m_div[k] = 0;
            end else if (ld_a[k]) begin
                m_idx[k] = int'(in_a[k]) % n;
                m_div[k] = 0;
            end else if (md != m_prev[k]) begin
                m_div[k] = 0;
            end else if (m_div[k] == p_div[k] - 1) begin
                m_div[k]  = 0;
                m_step[k] = 1;
                if (md == 1) begin
                    m_wrap[k] = (m_idx[k] == n - 1) ? 1 : 0;
                    m_idx[k]  = (m_idx[k] + 1) % n;
                end else begin
                    m_wrap[k] = (m_idx[k] == 0) ? 1 : 0;
                    m_idx[k]  = (m_idx[k] + n - 1) % n;
                end
            end else begin
                m_div[k] = m_div[k] + 1;
            end
            m_out[k] = model_sel(k, m_idx[k], 1'b1);
        end
        m_prev[k] = md;
    endtask

    // Advance one clock, update the models, sample #1 later and compare.
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_edge(k);
        #1;
        cyc++;
        check("d0.out",  32'(out0),  m_out[0]);
        check("d0.idx",  32'(idx0),  32'(m_idx[0]));
        check("d0.step", 32'(step0), 32'(m_step[0]));
        check("d0.wrap", 32'(wrap0), 32'(m_wrap[0]));
        check("d1.out",  32'(out1),  m_out[1]);
        check("d1.idx",  32'(idx1),  32'(m_idx[1]));
        check("d1.step", 32'(step1), 32'(m_step[1]));
        check("d1.wrap", 32'(wrap1), 32'(m_wrap[1]));
        check("d2.out",  32'(out2),  m_out[2]);
        check("d2.idx",  32'(idx2),  32'(m_idx[2]));
        check("d2.step", 32'(step2), 32'(m_step[2]));
        check("d2.wrap", 32'(wrap2), 32'(m_wrap[2]));
        $display("cyc %0d rst=%0d d0 out=%h idx=%0d s/w=%0d%0d | d1 out=%h idx=%0d s/w=%0d%0d | d2 out=%h idx=%0d s/w=%0d%0d",
                 cyc, rst, out0, idx0, step0, wrap0, out1, idx1, step1, wrap1,
                 out2, idx2, step2, wrap2);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            en_a[k] = 1'b1; md_a[k] = 2'b01; in_a[k] = '0; ld_a[k] = 1'b0;
            m_idx[k] = 0; m_div[k] = 0; m_prev[k] = 1; m_step[k] = 0; m_wrap[k] = 0;
            m_out[k] = '0;
        end

        // Reset held two cycles while scanning up.
        rst = 1'b1;
        ticks(2);
        check("rst.out0", 32'(out0), 32'h00);
        check("rst.idx0", 32'(idx0), 32'd0);
        check("rst.step0", 32'(step0), 32'd0);
        check("rst.wrap0", 32'(wrap0), 32'd0);
        check("rst.out2", 32'(out2), 32'hFFFF);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rel.nostep0", 32'(step0), 32'd0);
        end
        tick();
        check("rel.out0", 32'(out0), 32'h02);
        check("rel.step0", 32'(step0), 32'd1);

        // Direct sweep on instance 0, then disable.
        md_a[0] = 2'b00;
        for (int v = 0; v < 8; v++) begin
            in_a[0] = 4'(v);
            tick();
            check("dir.out0", 32'(out0), 32'd1 << v);
        end
        en_a[0] = 1'b0; in_a[0] = 4'd5;
        tick();
        check("dis.out0", 32'(out0), 32'h00);
        check("dis.idx0", 32'(idx0), 32'd7);

        // Scan up with wrap on instance 0.
        en_a[0] = 1'b1; md_a[0] = 2'b01; ld_a[0] = 1'b1; in_a[0] = 4'd6;
        tick();
        check("up.load.out0", 32'(out0), 32'h40);
        ld_a[0] = 1'b0;
        ticks(3);
        tick();
        check("up.out0.a", 32'(out0), 32'h80);
        check("up.step0.a", 32'(step0), 32'd1);
        check("up.wrap0.a", 32'(wrap0), 32'd0);
        ticks(3);
        tick();
        check("up.out0.b", 32'(out0), 32'h01);
        check("up.step0.b", 32'(step0), 32'd1);
        check("up.wrap0.b", 32'(wrap0), 32'd1);
        tick();
        check("up.wrap0.c", 32'(wrap0), 32'd0);

        // Scan down on the divide-by-1 instance.
        md_a[1] = 2'b10; ld_a[1] = 1'b1; in_a[1] = 4'd1;
        tick();
        check("dn.out1.a", 32'(out1), 32'h02);
        ld_a[1] = 1'b0;
        tick();
        check("dn.out1.b", 32'(out1), 32'h01);
        check("dn.step1.b", 32'(step1), 32'd1);
        tick();
        check("dn.out1.c", 32'(out1), 32'h80);
        check("dn.wrap1.c", 32'(wrap1), 32'd1);
        check("dn.step1.c", 32'(step1), 32'd1);
        tick();
        check("dn.out1.d", 32'(out1), 32'h40);
        check("dn.step1.d", 32'(step1), 32'd1);
        check("dn.wrap1.d", 32'(wrap1), 32'd0);

        // Load arriving on the same edge as a due step.
        ld_a[0] = 1'b1; in_a[0] = 4'd0;
        tick();
        ld_a[0] = 1'b0;
        ticks(3);
        ld_a[0] = 1'b1; in_a[0] = 4'd3;
        tick();
        check("ldp.idx0", 32'(idx0), 32'd3);
        check("ldp.out0", 32'(out0), 32'h08);
        check("ldp.step0", 32'(step0), 32'd0);
        ld_a[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ldp.nostep0", 32'(step0), 32'd0);
        end
        tick();
        check("ldp.idx0.b", 32'(idx0), 32'd4);
        check("ldp.step0.b", 32'(step0), 32'd1);

        // Active-low 4-bit instance: direct, hold, disable/re-enable.
        md_a[2] = 2'b00; in_a[2] = 4'd9;
        tick();
        check("al.dir.out2", 32'(out2), 32'hFDFF);
        md_a[2] = 2'b11; in_a[2] = 4'd2;
        tick();
        check("al.hold.out2", 32'(out2), 32'hFDFF);
        check("al.hold.idx2", 32'(idx2), 32'd9);
        en_a[2] = 1'b0;
        tick();
        check("al.dis.out2", 32'(out2), 32'hFFFF);
        check("al.dis.idx2", 32'(idx2), 32'd9);
        en_a[2] = 1'b1;
        tick();
        check("al.en.out2", 32'(out2), 32'hFDFF);
        check("al.en.idx2", 32'(idx2), 32'd9);

        // Randomised traffic against the reference model.
        for (int c = 0; c < 1200; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int k = 0; k < 3; k++) begin
                en_a[k] = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 7) == 0) md_a[k] = 2'($urandom_range(0, 3));
                ld_a[k] = ($urandom_range(0, 7) == 0);
                in_a[k] = 4'($urandom);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
